data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_arb_pkg.sv | 14 +
 rtl/data_bus_arb_rr2.sv | 22 ++
 rtl/data_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arb_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package data_bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   typedef logic master_id_t;

   localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

endpackage

// File: rtl/data_bus_arb_rr2.sv
// Combinational two-way round-robin pick: on a tie the master that did not win last goes next.
module arb_rr2
   import data_bus_arb_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  master_id_t last_id,
   output logic       valid,
   output master_id_t id
);

   always_comb begin
      valid = req0 | req1;
      id    = 1'b0;
      if (req0 && req1) begin
         id = ~last_id;
      end else if (req1) begin
         id = 1'b1;
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data-bus slave port, one transaction at a time.
// Optional bus watchdog compiled in with `define ARB_TIMEOUT_EN.
module data_bus_arbiter
   import data_bus_arb_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              M0_Read,
   input  logic              M0_Write,
   input  logic [ADDR_W-1:0] M0_Addr,
   input  logic [DATA_W-1:0] M0_WrData,
   output logic [DATA_W-1:0] M0_RdData,
   output logic              M0_Done,
   input  logic              M1_Read,
   input  logic              M1_Write,
   input  logic [ADDR_W-1:0] M1_Addr,
   input  logic [DATA_W-1:0] M1_WrData,
   output logic [DATA_W-1:0] M1_RdData,
   output logic              M1_Done,
   output logic              BusRead,
   output logic              BusWrite,
   output logic [ADDR_W-1:0] BusAddr,
   output logic [DATA_W-1:0] BusWrData,
   input  logic [DATA_W-1:0] BusRdData,
   input  logic              BusDone,
   output logic              Timeout,
   output logic [1:0]        dbg_state
);

   arb_state_t        state_q, state_d;
   master_id_t        last_id_q, last_id_d;
   master_id_t        owner_q, owner_d;
   logic              bus_read_q, bus_read_d;
   logic              bus_write_q, bus_write_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wrdata_q, bus_wrdata_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic              m0_done_q, m0_done_d;
   logic              m1_done_q, m1_done_d;
   logic              win_valid;
   master_id_t        win_id;
   logic              timeout_hit;
   logic              finish;
   logic [DATA_W-1:0] finish_data;

   arb_rr2 u_rr (
      .req0    (M0_Read | M0_Write),
      .req1    (M1_Read | M1_Write),
      .last_id (last_id_q),
      .valid   (win_valid),
      .id      (win_id)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   // A BusDone in the same cycle as expiry completes normally.
   assign timeout_hit = (state_q == GRANT) && !BusDone &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cnt_d       = (state_q == GRANT) ? cnt_q + CNT_W'(1) : '0;
   assign timeout_d   = timeout_hit;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign Timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
   assign Timeout            = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_valid) state_d = GRANT;
         GRANT:   if (BusDone || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_id_d    = last_id_q;
      owner_d      = owner_q;
      bus_read_d   = bus_read_q;
      bus_write_d  = bus_write_q;
      bus_addr_d   = bus_addr_q;
      bus_wrdata_d = bus_wrdata_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      m0_done_d    = 1'b0;
      m1_done_d    = 1'b0;
      finish       = 1'b0;
      finish_data  = BusRdData;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               owner_d   = win_id;
               last_id_d = win_id;
               // Read and Write together are treated as a write.
               if (win_id) begin
                  bus_write_d  = M1_Write;
                  bus_read_d   = M1_Read & ~M1_Write;
                  bus_addr_d   = M1_Addr;
                  bus_wrdata_d = M1_WrData;
               end else begin
                  bus_write_d  = M0_Write;
                  bus_read_d   = M0_Read & ~M0_Write;
                  bus_addr_d   = M0_Addr;
                  bus_wrdata_d = M0_WrData;
               end
            end
         end
         GRANT: begin
            if (BusDone || timeout_hit) begin
               finish      = 1'b1;
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
               if (!BusDone) finish_data = DATA_W'(TIMEOUT_RDATA);
`endif
            end
         end
         default: ;
      endcase
      if (finish) begin
         if (owner_q) begin
            m1_done_d  = 1'b1;
            m1_rdata_d = finish_data;
         end else begin
            m0_done_d  = 1'b1;
            m0_rdata_d = finish_data;
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         last_id_q    <= 1'b1;
         owner_q      <= 1'b0;
         bus_read_q   <= 1'b0;
         bus_write_q  <= 1'b0;
         bus_addr_q   <= '0;
         bus_wrdata_q <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         m0_done_q    <= 1'b0;
         m1_done_q    <= 1'b0;
      end else begin
         last_id_q    <= last_id_d;
         owner_q      <= owner_d;
         bus_read_q   <= bus_read_d;
         bus_write_q  <= bus_write_d;
         bus_addr_q   <= bus_addr_d;
         bus_wrdata_q <= bus_wrdata_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
         m0_done_q    <= m0_done_d;
         m1_done_q    <= m1_done_d;
      end
   end

   assign BusRead   = bus_read_q;
   assign BusWrite  = bus_write_q;
   assign BusAddr   = bus_addr_q;
   assign BusWrData = bus_wrdata_q;
   assign M0_RdData = m0_rdata_q;
   assign M1_RdData = m1_rdata_q;
   assign M0_Done   = m0_done_q;
   assign M1_Done   = m1_done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: vector table of master requests, bus responder model,
// scoreboards for bus transactions and Done/RdData returns, plus reset, spurious and watchdog sequences.
module tb_data_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int TO_CYC = 8;
`else
   localparam int TO_CYC = 1024;
`endif
   localparam int W = 34;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        M0_Read = 1'b0, M0_Write = 1'b0;
   logic [15:0] M0_Addr = '0, M0_WrData = '0;
   logic [15:0] M0_RdData;
   logic        M0_Done;
   logic        M1_Read = 1'b0, M1_Write = 1'b0;
   logic [15:0] M1_Addr = '0, M1_WrData = '0;
   logic [15:0] M1_RdData;
   logic        M1_Done;
   logic        BusRead, BusWrite;
   logic [15:0] BusAddr, BusWrData;
   logic [15:0] BusRdData = '0;
   logic        BusDone = 1'b0;
   logic        Timeout;
   logic [1:0]  dbg_state;

   data_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .Clock(Clock), .Resetn(Resetn),
      .M0_Read(M0_Read), .M0_Write(M0_Write), .M0_Addr(M0_Addr), .M0_WrData(M0_WrData),
      .M0_RdData(M0_RdData), .M0_Done(M0_Done),
      .M1_Read(M1_Read), .M1_Write(M1_Write), .M1_Addr(M1_Addr), .M1_WrData(M1_WrData),
      .M1_RdData(M1_RdData), .M1_Done(M1_Done),
      .BusRead(BusRead), .BusWrite(BusWrite), .BusAddr(BusAddr), .BusWrData(BusWrData),
      .BusRdData(BusRdData), .BusDone(BusDone), .Timeout(Timeout), .dbg_state(dbg_state)
   );

   always #5 Clock = ~Clock;

   // ---------------- checking infrastructure ----------------
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];        // {rd, wr, addr, wdata} expected on the bus
   logic [16:0]  exp_done_q[$];   // {id, rdata} expected at Done
   logic [15:0]  rd_last[2] = '{16'h0, 16'h0};
   int           gaps_q[$];
   int           done_count = 0;
   int           timeout_count = 0;
   int           last_cmd_len = 0;
   logic         last_done_to = 1'b0;

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] bus_mem(input logic [15:0] a);
      return a + 16'h0234;
   endfunction

   function automatic void push_txn(input bit id, input logic [1:0] op, input logic [15:0] a,
                                    input logic [15:0] d, input logic [15:0] rdat);
      exp_q.push_back({op == 2'd1, op[1], a, d});
      exp_done_q.push_back({id, rdat});
   endfunction

   // ---------------- bus responder model ----------------
   int   bus_lat = 3;     // 0 = never respond
   logic spurious_req = 1'b0;
   int   wait_cnt = 0;
   logic busy = 1'b0;

   initial begin
      forever begin
         @(posedge Clock);
         #1;
         BusDone = 1'b0;
         if (spurious_req) begin
            BusDone      = 1'b1;
            BusRdData    = 16'h7777;
            spurious_req = 1'b0;
         end else if (BusRead || BusWrite) begin
            if (!busy) begin
               busy     = 1'b1;
               wait_cnt = 1;
            end else begin
               wait_cnt++;
            end
            if (wait_cnt == bus_lat) begin
               BusDone   = 1'b1;
               BusRdData = bus_mem(BusAddr);
            end
         end else begin
            busy = 1'b0;
         end
      end
   end

   // ---------------- bus monitor / scoreboard ----------------
   logic prev_cmd = 1'b0;
   logic seen_any = 1'b0;
   int   idle_cnt = 0;
   int   cmd_len = 0;

   always @(posedge Clock) begin
      #1;
      if ((BusRead || BusWrite) && !prev_cmd) begin
         if (seen_any) begin
            chk("bus_gap_min2", 36'(idle_cnt >= 2), 36'd1);
            gaps_q.push_back(idle_cnt);
         end
         seen_any = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_txn: unexpected command %b%b addr %h, expected none", BusRead, BusWrite, BusAddr);
         end else begin
            chk("bus_txn", {BusRead, BusWrite, BusAddr, BusWrData}, exp_q.pop_front());
         end
         cmd_len = 0;
      end
      if (BusRead || BusWrite) begin
         cmd_len++;
         idle_cnt = 0;
      end else begin
         if (prev_cmd) last_cmd_len = cmd_len;
         idle_cnt++;
      end
      prev_cmd = BusRead || BusWrite;
   end

   // ---------------- Done / RdData monitor ----------------
   always @(posedge Clock) begin
      logic        id;
      logic [16:0] e;
      #1;
      if (Timeout) timeout_count++;
      if (M0_Done && M1_Done) chk("done_exclusive", 36'd1, 36'd0);
      if (M0_Done || M1_Done) begin
         done_count++;
         id = M1_Done;
         last_done_to = Timeout;
         if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got Done on M%0d, expected none", id);
         end else begin
            e = exp_done_q.pop_front();
            chk("done_id_rdata", {id, id ? M1_RdData : M0_RdData}, e);
            chk("nonowner_rdata_hold", id ? M0_RdData : M1_RdData, id ? rd_last[0] : rd_last[1]);
            if (e[16]) rd_last[1] = e[15:0];
            else       rd_last[0] = e[15:0];
         end
      end
   end

   // ---------------- master driver ----------------
   task automatic m_txn(input bit id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
      int n;
      if (id) begin
         M1_Read = op[0]; M1_Write = op[1]; M1_Addr = a; M1_WrData = d;
      end else begin
         M0_Read = op[0]; M0_Write = op[1]; M0_Addr = a; M0_WrData = d;
      end
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!(id ? M1_Done : M0_Done) && n < 300);
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL m%0d_wait_done: no Done after %0d cycles, expected Done", id, n);
      end
      if (id) begin
         M1_Read = 1'b0; M1_Write = 1'b0;
      end else begin
         M0_Read = 1'b0; M0_Write = 1'b0;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]  op0;   // 0 none, 1 read, 2 write, 3 read+write
      logic [15:0] a0;
      logic [15:0] d0;
      logic [1:0]  op1;
      logic [15:0] a1;
      logic [15:0] d1;
      int          lat;
      logic        first; // master expected to be granted first
   } vec_t;

   vec_t tv[10];

   initial begin
      int n;
      int done_before;
      logic sec;

      tv[0] = '{2'd2, 16'h0010, 16'hAAAA, 2'd2, 16'h0020, 16'h5555, 3, 1'b0};
      tv[1] = '{2'd1, 16'h1000, 16'h0000, 2'd0, 16'h0000, 16'h0000, 3, 1'b0};
      tv[2] = '{2'd0, 16'h0000, 16'h0000, 2'd1, 16'h0300, 16'h0F0F, 1, 1'b1};
      tv[3] = '{2'd1, 16'h0400, 16'h0101, 2'd1, 16'h0500, 16'h0202, 2, 1'b0};
      tv[4] = '{2'd3, 16'h0600, 16'h1111, 2'd2, 16'h0700, 16'h2222, 5, 1'b0};
      tv[5] = '{2'd0, 16'h0000, 16'h0000, 2'd2, 16'h0800, 16'h3333, 1, 1'b1};
      tv[6] = '{2'd1, 16'h0900, 16'h0A0A, 2'd3, 16'h0A00, 16'hBEEF, 4, 1'b0};
      tv[7] = '{2'd1, 16'h0B00, 16'h0000, 2'd0, 16'h0000, 16'h0000, 2, 1'b0};
      tv[8] = '{2'd1, 16'h0C00, 16'h0C0C, 2'd1, 16'h0D00, 16'h0D0D, 3, 1'b1};
      tv[9] = '{2'd0, 16'h0000, 16'h0000, 2'd1, 16'h0D10, 16'h0000, 2, 1'b1};

      // ---- reset state ----
      repeat (3) @(posedge Clock);
      #1;
      chk("rst_bus_read", BusRead, 0);
      chk("rst_bus_write", BusWrite, 0);
      chk("rst_bus_addr", BusAddr, 0);
      chk("rst_bus_wrdata", BusWrData, 0);
      chk("rst_m0_rdata", M0_RdData, 0);
      chk("rst_m1_rdata", M1_RdData, 0);
      chk("rst_m0_done", M0_Done, 0);
      chk("rst_m1_done", M1_Done, 0);
      chk("rst_timeout", Timeout, 0);
      chk("rst_state", dbg_state, 0);
      Resetn = 1'b1;
      repeat (2) @(posedge Clock);
      #1;

      // ---- table-driven transactions ----
      for (int i = 0; i < 10; i++) begin
         bus_lat = tv[i].lat;
         if (tv[i].op0 != 2'd0 && tv[i].op1 != 2'd0) begin
            sec = ~tv[i].first;
            if (tv[i].first) push_txn(1'b1, tv[i].op1, tv[i].a1, tv[i].d1, bus_mem(tv[i].a1));
            else             push_txn(1'b0, tv[i].op0, tv[i].a0, tv[i].d0, bus_mem(tv[i].a0));
            if (sec) push_txn(1'b1, tv[i].op1, tv[i].a1, tv[i].d1, bus_mem(tv[i].a1));
            else     push_txn(1'b0, tv[i].op0, tv[i].a0, tv[i].d0, bus_mem(tv[i].a0));
         end else if (tv[i].op0 != 2'd0) begin
            push_txn(1'b0, tv[i].op0, tv[i].a0, tv[i].d0, bus_mem(tv[i].a0));
         end else begin
            push_txn(1'b1, tv[i].op1, tv[i].a1, tv[i].d1, bus_mem(tv[i].a1));
         end
         fork
            begin if (tv[i].op0 != 2'd0) m_txn(1'b0, tv[i].op0, tv[i].a0, tv[i].d0); end
            begin if (tv[i].op1 != 2'd0) m_txn(1'b1, tv[i].op1, tv[i].a1, tv[i].d1); end
         join
         if (tv[i].op0 != 2'd0 && tv[i].op1 != 2'd0)
            chk($sformatf("vec%0d_turnaround", i), gaps_q[gaps_q.size()-1], 2);
         repeat (3) @(posedge Clock);
         #1;
      end

      // ---- spurious BusDone while idle ----
      done_before  = done_count;
      spurious_req = 1'b1;
      repeat (4) @(posedge Clock);
      #1;
      chk("spurious_state_idle", dbg_state, 0);
      chk("spurious_no_done", done_count, done_before);
      chk("spurious_no_cmd", BusRead | BusWrite, 0);

      // ---- round robin: M0 back-to-back while M1 holds ----
      bus_lat = 2;
      gaps_q.delete();
      push_txn(1'b0, 2'd1, 16'h2000, 16'h0000, bus_mem(16'h2000));
      push_txn(1'b1, 2'd1, 16'h3000, 16'h0000, bus_mem(16'h3000));
      push_txn(1'b0, 2'd1, 16'h2002, 16'h0000, bus_mem(16'h2002));
      push_txn(1'b1, 2'd1, 16'h3002, 16'h0000, bus_mem(16'h3002));
      push_txn(1'b0, 2'd1, 16'h2004, 16'h0000, bus_mem(16'h2004));
      fork
         begin
            m_txn(1'b0, 2'd1, 16'h2000, 16'h0000);
            m_txn(1'b0, 2'd1, 16'h2002, 16'h0000);
            m_txn(1'b0, 2'd1, 16'h2004, 16'h0000);
         end
         begin
            m_txn(1'b1, 2'd1, 16'h3000, 16'h0000);
            m_txn(1'b1, 2'd1, 16'h3002, 16'h0000);
         end
      join
      chk("rr_grant_count", gaps_q.size(), 5);
      for (int g = 1; g < gaps_q.size(); g++)
         chk($sformatf("rr_gap%0d", g), gaps_q[g], 2);
      repeat (3) @(posedge Clock);
      #1;

      // ---- reset asserted during GRANT ----
      bus_lat = 100;
      push_txn(1'b0, 2'd2, 16'h0E00, 16'h4444, bus_mem(16'h0E00));
      exp_q.push_back({1'b0, 1'b1, 16'h0E00, 16'h4444});   // re-grant after reset
      exp_done_q.delete();
      M0_Write = 1'b1; M0_Addr = 16'h0E00; M0_WrData = 16'h4444;
      n = 0;
      while (!BusWrite && n < 20) begin
         @(posedge Clock);
         #1;
         n++;
      end
      chk("rst_mid_granted", BusWrite, 1);
      repeat (2) @(posedge Clock);
      #3;
      done_before = done_count;
      Resetn = 1'b0;
      #1;
      chk("rst_mid_bus_write_drop", BusWrite, 0);
      chk("rst_mid_bus_read_drop", BusRead, 0);
      chk("rst_mid_state", dbg_state, 0);
      chk("rst_mid_m0_rdata", M0_RdData, 0);
      rd_last[0] = 16'h0;
      rd_last[1] = 16'h0;
      repeat (2) @(posedge Clock);
      #1;
      bus_lat = 3;
      exp_done_q.push_back({1'b0, bus_mem(16'h0E00)});
      Resetn = 1'b1;
      chk("rst_mid_no_done", done_count, done_before);
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!M0_Done && n < 50);
      chk("rst_regrant_done", M0_Done, 1);
      M0_Write = 1'b0;
      repeat (3) @(posedge Clock);
      #1;

`ifdef ARB_TIMEOUT_EN
      // ---- watchdog: bus never answers ----
      bus_lat = 0;
      push_txn(1'b0, 2'd1, 16'h0F00, 16'h0000, 16'hDEAD);
      m_txn(1'b0, 2'd1, 16'h0F00, 16'h0000);
      chk("to_with_done", last_done_to, 1);
      #2;
      chk("to_cmd_dropped", BusRead | BusWrite, 0);
      chk("to_cmd_len", last_cmd_len, TO_CYC);
      repeat (3) @(posedge Clock);
      #1;
      chk("to_pulse_count", timeout_count, 1);
`else
      chk("no_timeout_pulse", timeout_count, 0);
`endif

      chk("bus_queue_empty", exp_q.size(), 0);
      chk("done_queue_empty", exp_done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
